move_player: RTL and testbench

MOVE_PLAYER -- requirements
Module: move_player

---
 rtl/move_player_pkg.sv | 80 ++++++++
 rtl/move_player_btn_debounce.sv | 50 +++++
 rtl/move_player.sv | 208 ++++++++++++++++++++
 tb/tb_move_player.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_player_pkg.sv
// Shared definitions for the move player: direction codes, FSM states, glyphs.
package move_player_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        RIGHT = 2'd2,
        LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        AUTO  = 2'd2,
        EMPTY = 2'd3
    } state_e;

    // Four-digit display payload, seg3 is the leftmost digit.
    typedef struct packed {
        logic [6:0] seg3;
        logic [6:0] seg2;
        logic [6:0] seg1;
        logic [6:0] seg0;
    } disp_t;

    // Active-low glyphs, bit order gfedcba.
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_U     = 7'h41;
    localparam logic [6:0] GLYPH_P     = 7'h0C;
    localparam logic [6:0] GLYPH_D     = 7'h21;
    localparam logic [6:0] GLYPH_O     = 7'h40;
    localparam logic [6:0] GLYPH_R     = 7'h2F;
    localparam logic [6:0] GLYPH_I     = 7'h4F;
    localparam logic [6:0] GLYPH_L     = 7'h47;
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_DIG0  = 7'h40;
    localparam logic [6:0] GLYPH_DIG1  = 7'h79;
    localparam logic [6:0] GLYPH_DIG2  = 7'h24;
    localparam logic [6:0] GLYPH_DIG3  = 7'h30;
    localparam logic [6:0] GLYPH_DIG4  = 7'h19;
    localparam logic [6:0] GLYPH_DIG5  = 7'h12;
    localparam logic [6:0] GLYPH_DIG6  = 7'h02;
    localparam logic [6:0] GLYPH_DIG7  = 7'h78;
    localparam logic [6:0] GLYPH_DIG8  = 7'h00;
    localparam logic [6:0] GLYPH_DIG9  = 7'h10;

    // Decimal digit to glyph; out-of-range values show blank.
    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    digit_glyph = GLYPH_DIG0;
            4'd1:    digit_glyph = GLYPH_DIG1;
            4'd2:    digit_glyph = GLYPH_DIG2;
            4'd3:    digit_glyph = GLYPH_DIG3;
            4'd4:    digit_glyph = GLYPH_DIG4;
            4'd5:    digit_glyph = GLYPH_DIG5;
            4'd6:    digit_glyph = GLYPH_DIG6;
            4'd7:    digit_glyph = GLYPH_DIG7;
            4'd8:    digit_glyph = GLYPH_DIG8;
            4'd9:    digit_glyph = GLYPH_DIG9;
            default: digit_glyph = GLYPH_BLANK;
        endcase
    endfunction

    // Direction to two-letter abbreviation {left glyph, right glyph}.
    function automatic logic [13:0] letter_pair(input dir_e d);
        case (d)
            UP:      letter_pair = {GLYPH_U, GLYPH_P};
            DOWN:    letter_pair = {GLYPH_D, GLYPH_O};
            RIGHT:   letter_pair = {GLYPH_R, GLYPH_I};
            default: letter_pair = {GLYPH_L, GLYPH_E};
        endcase
    endfunction

    // Split 0..99 into {tens, units}.
    function automatic logic [7:0] dec_split(input logic [6:0] n);
        dec_split = {4'(n / 7'd10), 4'(n % 7'd10)};
    endfunction

endpackage

// File: rtl/move_player_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          sync_d;
    logic [CW-1:0] cnt;
    logic          level;
    logic          armed;

    // A press only counts once a released level has been accepted since reset,
    // so a button held through reset never produces a pulse on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            armed  <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync1  <= btn;
            sync2  <= sync1;
            sync_d <= sync2;
            pulse  <= 1'b0;
            if (sync2 != sync_d) begin
                cnt <= '0;
            end else if (cnt != CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt <= cnt + CW'(1);
            end else begin
                level <= sync_d;
                if (!sync_d) begin
                    armed <= 1'b1;
                end
                pulse <= sync_d && !level && armed;
            end
        end
    end

endmodule

// File: rtl/move_player.sv
// Steps through a recorded move list and shows each move on a 4-digit display.
module move_player
    import move_player_pkg::*;
#(
    parameter int unsigned MAX_MOVES       = 31,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned AUTO_PERIOD     = 50000000,
    parameter int unsigned WRAP            = 0
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 comp,
    input  logic [2*MAX_MOVES-1:0]                               ord,
    input  logic [$clog2(MAX_MOVES+1)-1:0]                       num_moves,
    input  logic                                                 btn_next,
    input  logic                                                 btn_prev,
    input  logic                                                 btn_auto,
    output logic [6:0]                                           seg0,
    output logic [6:0]                                           seg1,
    output logic [6:0]                                           seg2,
    output logic [6:0]                                           seg3,
    output logic [((MAX_MOVES > 1) ? $clog2(MAX_MOVES) : 1)-1:0] step,
    output logic                                                 last
);

    localparam int unsigned NW = $clog2(MAX_MOVES + 1);
    localparam int unsigned SW = (MAX_MOVES > 1) ? $clog2(MAX_MOVES) : 1;
    localparam int unsigned TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    state_e        state;
    state_e        state_next;
    logic [SW-1:0] step_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic [NW-1:0] nm;
    logic [NW-1:0] nm_next;
    logic          last_next;
    logic          comp_d;
    logic          comp_rise;
    logic [SW-1:0] last_idx;
    logic          next_p;
    logic          prev_p;
    logic          auto_p;
    disp_t         disp;
    disp_t         disp_next;
    logic [7:0]    split;
    dir_e          mv;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(clk), .rst(rst), .btn(btn_next), .pulse(next_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk(clk), .rst(rst), .btn(btn_prev), .pulse(prev_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_auto (
        .clk(clk), .rst(rst), .btn(btn_auto), .pulse(auto_p)
    );

    // Forward step: saturate or wrap at the last valid move.
    function automatic logic [SW-1:0] step_inc(input logic [SW-1:0] s, input logic [SW-1:0] l);
        if (s >= l) begin
            step_inc = (WRAP != 0) ? '0 : l;
        end else begin
            step_inc = s + SW'(1);
        end
    endfunction

    // Backward step: saturate at 0 or wrap to the last valid move.
    function automatic logic [SW-1:0] step_dec(input logic [SW-1:0] s, input logic [SW-1:0] l);
        if (s == '0) begin
            step_dec = (WRAP != 0) ? l : '0;
        end else if (s > l) begin
            step_dec = l;
        end else begin
            step_dec = s - SW'(1);
        end
    endfunction

    // Simultaneous next and prev cancel out.
    function automatic logic [SW-1:0] step_move(input logic [SW-1:0] s, input logic n,
                                                input logic p, input logic [SW-1:0] l);
        if (n && !p) begin
            step_move = step_inc(s, l);
        end else if (p && !n) begin
            step_move = step_dec(s, l);
        end else begin
            step_move = s;
        end
    endfunction

    assign comp_rise = comp && !comp_d;
    assign last_idx  = SW'(nm - NW'(1));

    // State, step, timer and latched move count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            step   <= '0;
            timer  <= '0;
            nm     <= '0;
            comp_d <= 1'b0;
            last   <= 1'b0;
        end else begin
            state  <= state_next;
            step   <= step_next;
            timer  <= timer_next;
            nm     <= nm_next;
            comp_d <= comp;
            last   <= last_next;
        end
    end

    // Next-state, step and auto-timer logic.
    always_comb begin
        state_next = state;
        step_next  = step;
        timer_next = timer;
        nm_next    = nm;
        last_next  = 1'b0;
        case (state)
            IDLE: begin
                step_next  = '0;
                timer_next = '0;
                if (comp_rise) begin
                    nm_next    = (num_moves > NW'(MAX_MOVES)) ? NW'(MAX_MOVES) : num_moves;
                    state_next = (num_moves == '0) ? EMPTY : SHOW;
                end
            end
            SHOW: begin
                timer_next = '0;
                if (!comp) begin
                    state_next = IDLE;
                    step_next  = '0;
                end else begin
                    step_next = step_move(step, next_p, prev_p, last_idx);
                    if (auto_p) begin
                        state_next = AUTO;
                    end
                end
            end
            AUTO: begin
                if (!comp) begin
                    state_next = IDLE;
                    step_next  = '0;
                    timer_next = '0;
                end else begin
                    if (next_p || prev_p) begin
                        step_next  = step_move(step, next_p, prev_p, last_idx);
                        timer_next = '0;
                    end else if (timer == TW'(AUTO_PERIOD - 1)) begin
                        step_next  = step_inc(step, last_idx);
                        timer_next = '0;
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                    if (auto_p) begin
                        state_next = SHOW;
                        timer_next = '0;
                    end else if (WRAP == 0 && step_next == last_idx) begin
                        state_next = SHOW;
                    end
                end
            end
            EMPTY: begin
                step_next  = '0;
                timer_next = '0;
                if (!comp) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                step_next  = '0;
                timer_next = '0;
            end
        endcase
        last_next = (state_next == SHOW || state_next == AUTO) &&
                    (step_next == SW'(nm_next - NW'(1)));
    end

    // Display content derived from the current state and step.
    always_comb begin
        disp_next = {GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK};
        split     = dec_split(7'(step) + 7'd1);
        mv        = dir_e'(ord[{step, 1'b0} +: 2]);
        case (state)
            SHOW, AUTO: disp_next = {letter_pair(mv), digit_glyph(split[7:4]),
                                     digit_glyph(split[3:0])};
            EMPTY:      disp_next = {GLYPH_DASH, GLYPH_DASH, GLYPH_DIG0, GLYPH_DIG0};
            default:    disp_next = {GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK};
        endcase
    end

    // Registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp <= {GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK};
        end else begin
            disp <= disp_next;
        end
    end

    assign seg3 = disp.seg3;
    assign seg2 = disp.seg2;
    assign seg1 = disp.seg1;
    assign seg0 = disp.seg0;

endmodule

// File: tb/tb_move_player.sv
// Self-checking bench: one saturating and one wrapping instance on shared stimulus.
module tb_move_player;

    localparam int unsigned MM = 31;
    localparam int unsigned DC = 4;
    localparam int unsigned AP = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            comp;
    logic [2*MM-1:0] ord;
    logic [4:0]      num_moves;
    logic            btn_next;
    logic            btn_prev;
    logic            btn_auto;

    logic [6:0] a_s0, a_s1, a_s2, a_s3, b_s0, b_s1, b_s2, b_s3;
    logic [4:0] a_step, b_step;
    logic       a_last, b_last;

    int n_tests = 0;
    int n_fail  = 0;

    move_player #(.MAX_MOVES(MM), .DEBOUNCE_CYCLES(DC), .AUTO_PERIOD(AP), .WRAP(0)) u_w0 (
        .clk(clk), .rst(rst), .comp(comp), .ord(ord), .num_moves(num_moves),
        .btn_next(btn_next), .btn_prev(btn_prev), .btn_auto(btn_auto),
        .seg0(a_s0), .seg1(a_s1), .seg2(a_s2), .seg3(a_s3), .step(a_step), .last(a_last)
    );

    move_player #(.MAX_MOVES(MM), .DEBOUNCE_CYCLES(DC), .AUTO_PERIOD(AP), .WRAP(1)) u_w1 (
        .clk(clk), .rst(rst), .comp(comp), .ord(ord), .num_moves(num_moves),
        .btn_next(btn_next), .btn_prev(btn_prev), .btn_auto(btn_auto),
        .seg0(b_s0), .seg1(b_s1), .seg2(b_s2), .seg3(b_s3), .step(b_step), .last(b_last)
    );

    always #5 clk = ~clk;

    // Reference glyphs, active-low gfedcba.
    localparam logic [6:0] T_BLANK = 7'h7F;
    localparam logic [6:0] T_DASH  = 7'h3F;

    function automatic logic [6:0] t_digit(input int d);
        case (d)
            0: t_digit = 7'h40;  1: t_digit = 7'h79;  2: t_digit = 7'h24;
            3: t_digit = 7'h30;  4: t_digit = 7'h19;  5: t_digit = 7'h12;
            6: t_digit = 7'h02;  7: t_digit = 7'h78;  8: t_digit = 7'h00;
            default: t_digit = 7'h10;
        endcase
    endfunction

    // UP=0 "UP", DOWN=1 "dO", RIGHT=2 "rI", LEFT=3 "LE".
    function automatic logic [13:0] t_pair(input logic [1:0] c);
        case (c)
            2'd0:    t_pair = {7'h41, 7'h0C};
            2'd1:    t_pair = {7'h21, 7'h40};
            2'd2:    t_pair = {7'h2F, 7'h4F};
            default: t_pair = {7'h47, 7'h06};
        endcase
    endfunction

    function automatic logic [27:0] t_disp(input int st);
        logic [1:0] c;
        c = ord[2*st +: 2];
        t_disp = {t_pair(c), t_digit((st + 1) / 10), t_digit((st + 1) % 10)};
    endfunction

    function automatic logic [27:0] get_disp(input int inst);
        get_disp = (inst == 0) ? {a_s3, a_s2, a_s1, a_s0} : {b_s3, b_s2, b_s1, b_s0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected outputs per instance.
    typedef struct {
        string      name;
        int         inst;
        logic [27:0] disp;
        int         st;
        logic       lst;
    } exp_t;
    exp_t sb[$];

    task automatic push_exp(input string name, input int inst, input logic [27:0] d,
                            input int st, input logic lst);
        exp_t e;
        e.name = name; e.inst = inst; e.disp = d; e.st = st; e.lst = lst;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.name, "_disp"}, 32'(get_disp(e.inst)), 32'(e.disp));
            check({e.name, "_step"}, 32'((e.inst == 0) ? a_step : b_step), 32'(e.st));
            check({e.name, "_last"}, 32'((e.inst == 0) ? a_last : b_last), 32'(e.lst));
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int which, input logic v);
        if (which == 0) btn_next = v;
        else if (which == 1) btn_prev = v;
        else btn_auto = v;
    endtask

    // Press and release a button; optionally with a 3-cycle bounce first.
    task automatic press(input int which, input bit bounce);
        @(negedge clk);
        if (bounce) begin
            set_btn(which, 1'b1); @(negedge clk);
            set_btn(which, 1'b0); @(negedge clk);
            set_btn(which, 1'b1); @(negedge clk);
        end
        set_btn(which, 1'b1);
        cycles(10);
        set_btn(which, 1'b0);
        cycles(12);
    endtask

    typedef struct {
        int act;   // 0 start (comp rise), 1 next, 2 prev
        int st0;
        bit l0;
        int st1;
        bit l1;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int   aq[$];
        int   cyc, last_chg, prev0, prev1, exp1, e;
        bit   saw9, found;

        tbl[0] = '{0, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 0, 1, 0};
        tbl[2] = '{1, 2, 1, 2, 1};
        tbl[3] = '{1, 2, 1, 0, 0};
        tbl[4] = '{2, 1, 0, 2, 1};
        tbl[5] = '{2, 0, 0, 1, 0};
        tbl[6] = '{2, 0, 0, 0, 0};
        tbl[7] = '{2, 0, 0, 2, 1};

        rst = 1'b1; comp = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; btn_auto = 1'b0;
        num_moves = 5'd0; ord = '0;
        cycles(2);
        push_exp("reset_w0", 0, {4{T_BLANK}}, 0, 1'b0);
        push_exp("reset_w1", 1, {4{T_BLANK}}, 0, 1'b0);
        drain();
        rst = 1'b0;
        cycles(12);

        // Bounced press yields a single step.
        num_moves = 5'd3;
        ord = 62'(6'b11_10_00);
        comp = 1'b1;
        cycles(3);
        push_exp("start_w0", 0, t_disp(0), 0, 1'b0);
        drain();
        press(0, 1'b1);
        push_exp("bounce_w0", 0, t_disp(1), 1, 1'b0);
        push_exp("bounce_w1", 1, t_disp(1), 1, 1'b0);
        drain();

        // comp falling: step cleared first, display blank one cycle later.
        comp = 1'b0;
        @(negedge clk);
        check("comp_fall_step", 32'(a_step), 32'd0);
        @(negedge clk);
        check("comp_fall_blank", 32'(get_disp(0)), 32'({4{T_BLANK}}));

        // Table: stepping and boundary behaviour for saturating vs wrapping.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].act == 0) begin
                comp = 1'b1;
                cycles(3);
            end else begin
                press(tbl[i].act - 1, 1'b0);
            end
            push_exp($sformatf("vec%0d_w0", i), 0, t_disp(tbl[i].st0), tbl[i].st0, tbl[i].l0);
            push_exp($sformatf("vec%0d_w1", i), 1, t_disp(tbl[i].st1), tbl[i].st1, tbl[i].l1);
            drain();
        end

        // Empty move list.
        comp = 1'b0; cycles(3);
        num_moves = 5'd0; comp = 1'b1; cycles(3);
        push_exp("empty_w0", 0, {T_DASH, T_DASH, t_digit(0), t_digit(0)}, 0, 1'b0);
        push_exp("empty_w1", 1, {T_DASH, T_DASH, t_digit(0), t_digit(0)}, 0, 1'b0);
        drain();
        comp = 1'b0; cycles(2);
        push_exp("empty_off", 0, {4{T_BLANK}}, 0, 1'b0);
        drain();

        // Auto playback over 12 moves.
        num_moves = 5'd12;
        ord = 62'({$urandom(), $urandom()});
        comp = 1'b1; cycles(3);
        push_exp("auto_start", 0, t_disp(0), 0, 1'b0);
        drain();
        for (int s = 1; s <= 11; s++) aq.push_back(s);
        prev0 = 0; prev1 = 0; exp1 = 0; last_chg = -1; cyc = 0; saw9 = 0;
        while (cyc < 300 && aq.size() != 0) begin
            btn_auto = (cyc < 10);
            @(negedge clk);
            cyc++;
            if (saw9) begin
                check("auto_disp9", 32'(get_disp(0)), 32'(t_disp(9)));
                saw9 = 0;
            end
            if (32'(a_step) != 32'(prev0)) begin
                e = aq.pop_front();
                check("auto_step_w0", 32'(a_step), 32'(e));
                if (last_chg >= 0) check("auto_period", 32'(cyc - last_chg), 32'(AP));
                last_chg = cyc;
                prev0 = int'(a_step);
                if (a_step == 5'd9) saw9 = 1;
            end
            if (32'(b_step) != 32'(prev1)) begin
                exp1 = (exp1 + 1) % 12;
                check("auto_step_w1", 32'(b_step), 32'(exp1));
                prev1 = int'(b_step);
            end
        end
        btn_auto = 1'b0;
        if (aq.size() != 0) check("auto_timeout", 32'(aq.size()), 32'd0);
        cycles(24);
        check("auto_hold_step", 32'(a_step), 32'd11);
        check("auto_hold_last", 32'(a_last), 32'd1);

        // Reset during auto playback at step 5, button held across release.
        comp = 1'b0; cycles(3);
        comp = 1'b1; cycles(3);
        cyc = 0; found = 0;
        while (cyc < 300 && !found) begin
            btn_auto = (cyc < 10);
            @(negedge clk);
            cyc++;
            if (a_step == 5'd5) found = 1;
        end
        btn_auto = 1'b0;
        check("reach_step5", 32'(found), 32'd1);
        btn_next = 1'b1;
        rst = 1'b1;
        #1;
        push_exp("rst_auto_w0", 0, {4{T_BLANK}}, 0, 1'b0);
        push_exp("rst_auto_w1", 1, {4{T_BLANK}}, 0, 1'b0);
        drain();
        cycles(3);
        rst = 1'b0;
        cycles(40);
        check("held_w0_step", 32'(a_step), 32'd0);
        check("held_w1_step", 32'(b_step), 32'd0);
        btn_next = 1'b0;
        cycles(15);
        check("release_w0_step", 32'(a_step), 32'd0);
        press(0, 1'b0);
        push_exp("after_rst_w0", 0, t_disp(1), 1, 1'b0);
        push_exp("after_rst_w1", 1, t_disp(1), 1, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
